// File: rtl/ptw_axi_pkg.sv
// Shared AXI constants and FSM state type for the page-table-walker read engine.
package ptw_axi_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_8B     = 3'd3;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [2:0] PROT_PTW    = 3'b001;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAr   = 2'd1,
    StR    = 2'd2
  } ptw_state_e;

endpackage

// File: rtl/ptw_axi_reader.sv
// Single-outstanding one-beat AXI4 read engine for the ITLB page-table walker.
// Define PTW_RESP_CHECK_EN to turn SLVERR/DECERR responses into ACCESS_FAULT pulses.
module ptw_axi_reader
  import ptw_axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned PTW_ID     = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ADDR_TO_AXIM_VALID,
  input  logic [ADDR_WIDTH-1:0] ADDR_TO_AXIM,
  input  logic                  FLUSH,
  output logic                  DATA_FROM_AXIM_VALID,
  output logic [DATA_WIDTH-1:0] DATA_FROM_AXIM,
  output logic                  ACCESS_FAULT,
  output logic                  BUSY,
  output logic [ID_WIDTH-1:0]   M_ARID,
  output logic [ADDR_WIDTH-1:0] M_ARADDR,
  output logic [7:0]            M_ARLEN,
  output logic [2:0]            M_ARSIZE,
  output logic [1:0]            M_ARBURST,
  output logic [2:0]            M_ARPROT,
  output logic                  M_ARVALID,
  input  logic                  M_ARREADY,
  input  logic [ID_WIDTH-1:0]   M_RID,
  input  logic [DATA_WIDTH-1:0] M_RDATA,
  input  logic [1:0]            M_RRESP,
  input  logic                  M_RLAST,
  input  logic                  M_RVALID,
  output logic                  M_RREADY
);

  localparam logic [ID_WIDTH-1:0] PtwId = ID_WIDTH'(PTW_ID);

  ptw_state_e state_q, state_d;
  logic                  discard_q, discard_d;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  data_valid_q;
  logic                  fault_q;

  logic req_take;
  logic beat_ok;
  logic deliver;
  logic resp_err;

  assign req_take = (state_q == StIdle) && ADDR_TO_AXIM_VALID && !FLUSH;
  assign beat_ok  = (state_q == StR) && M_RVALID && (M_RID == PtwId);
  // A flush landing on the completing beat still discards it.
  assign deliver  = beat_ok && !(discard_q || FLUSH);

`ifdef PTW_RESP_CHECK_EN
  assign resp_err = M_RRESP[1];
`else
  assign resp_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    unique case (state_q)
      StIdle: begin
        if (req_take) state_d = StAr;
      end
      StAr: begin
        if (FLUSH) discard_d = 1'b1;
        if (M_ARREADY) state_d = StR;
      end
      StR: begin
        if (FLUSH) discard_d = 1'b1;
        if (beat_ok) begin
          state_d   = StIdle;
          discard_d = 1'b0;
        end
      end
      default: begin
        state_d   = StIdle;
        discard_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= StIdle;
      discard_q    <= 1'b0;
      araddr_q     <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      discard_q    <= discard_d;
      data_valid_q <= deliver && !resp_err;
      fault_q      <= deliver && resp_err;
      if (req_take) araddr_q <= {ADDR_TO_AXIM[ADDR_WIDTH-1:3], 3'b000};
      if (deliver && !resp_err) data_q <= M_RDATA;
    end
  end

  assign M_ARID    = PtwId;
  assign M_ARADDR  = araddr_q;
  assign M_ARLEN   = 8'd0;
  assign M_ARSIZE  = SIZE_8B;
  assign M_ARBURST = BURST_INCR;
  assign M_ARPROT  = PROT_PTW;
  assign M_ARVALID = (state_q == StAr);
  assign M_RREADY  = (state_q == StR);

  assign BUSY                 = (state_q != StIdle);
  assign DATA_FROM_AXIM_VALID = data_valid_q;
  assign DATA_FROM_AXIM       = data_q;
  assign ACCESS_FAULT         = fault_q;

  logic unused_inputs;
  assign unused_inputs = ^{M_RLAST, M_RRESP, ADDR_TO_AXIM[2:0]};

endmodule

// File: tb/tb_ptw_axi_reader.sv
// Self-checking bench for ptw_axi_reader: directed walks plus randomized walks against a
// transaction-level model of the expected response.
module tb_ptw_axi_reader;

`ifdef PTW_RESP_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif
  localparam logic [3:0] PtwId = 4'd0;

  logic        CLK;
  logic        RST;
  logic        ADDR_TO_AXIM_VALID;
  logic [63:0] ADDR_TO_AXIM;
  logic        FLUSH;
  logic        DATA_FROM_AXIM_VALID;
  logic [63:0] DATA_FROM_AXIM;
  logic        ACCESS_FAULT;
  logic        BUSY;
  logic [3:0]  M_ARID;
  logic [63:0] M_ARADDR;
  logic [7:0]  M_ARLEN;
  logic [2:0]  M_ARSIZE;
  logic [1:0]  M_ARBURST;
  logic [2:0]  M_ARPROT;
  logic        M_ARVALID;
  logic        M_ARREADY;
  logic [3:0]  M_RID;
  logic [63:0] M_RDATA;
  logic [1:0]  M_RRESP;
  logic        M_RLAST;
  logic        M_RVALID;
  logic        M_RREADY;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] model_data;

  ptw_axi_reader #(
    .ADDR_WIDTH(64),
    .DATA_WIDTH(64),
    .ID_WIDTH  (4),
    .PTW_ID    (0)
  ) dut (
    .CLK                 (CLK),
    .RST                 (RST),
    .ADDR_TO_AXIM_VALID  (ADDR_TO_AXIM_VALID),
    .ADDR_TO_AXIM        (ADDR_TO_AXIM),
    .FLUSH               (FLUSH),
    .DATA_FROM_AXIM_VALID(DATA_FROM_AXIM_VALID),
    .DATA_FROM_AXIM      (DATA_FROM_AXIM),
    .ACCESS_FAULT        (ACCESS_FAULT),
    .BUSY                (BUSY),
    .M_ARID              (M_ARID),
    .M_ARADDR            (M_ARADDR),
    .M_ARLEN             (M_ARLEN),
    .M_ARSIZE            (M_ARSIZE),
    .M_ARBURST           (M_ARBURST),
    .M_ARPROT            (M_ARPROT),
    .M_ARVALID           (M_ARVALID),
    .M_ARREADY           (M_ARREADY),
    .M_RID               (M_RID),
    .M_RDATA             (M_RDATA),
    .M_RRESP             (M_RRESP),
    .M_RLAST             (M_RLAST),
    .M_RVALID            (M_RVALID),
    .M_RREADY            (M_RREADY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One walk: request, ar_wait stalled AR cycles, r_wait R cycles (the first `foreign` of them
  // carrying RID=5 beats), then the PTW_ID beat. flush_at is a cycle index after the pulse.
  task automatic walk(input logic [63:0] addr, input int ar_wait, input int r_wait,
                      input int flush_at, input int foreign, input logic [1:0] resp,
                      input logic [63:0] rdata, input bit extra_req);
    logic [63:0] exp_addr;
    bit flushed;
    bit exp_dv;
    bit exp_f;
    int c;
    exp_addr = {addr[63:3], 3'b000};
    flushed = 1'b0;
    ADDR_TO_AXIM_VALID = 1'b1;
    ADDR_TO_AXIM = addr;
    FLUSH = 1'b0;
    @(negedge CLK);
    ADDR_TO_AXIM_VALID = 1'b0;
    c = 1;
    for (int i = 0; i < ar_wait; i++) begin
      chk("ar_wait_arvalid", M_ARVALID, 1);
      chk("ar_wait_araddr", M_ARADDR, exp_addr);
      chk("ar_wait_rready", M_RREADY, 0);
      ADDR_TO_AXIM_VALID = extra_req && (i == 0);
      ADDR_TO_AXIM = ~addr;
      FLUSH = (c == flush_at);
      flushed |= FLUSH;
      @(negedge CLK);
      c++;
    end
    ADDR_TO_AXIM_VALID = 1'b0;
    chk("ar_hs_arvalid", M_ARVALID, 1);
    chk("ar_hs_araddr", M_ARADDR, exp_addr);
    chk("ar_hs_busy", BUSY, 1);
    M_ARREADY = 1'b1;
    FLUSH = (c == flush_at);
    flushed |= FLUSH;
    @(negedge CLK);
    c++;
    M_ARREADY = 1'b0;
    for (int j = 0; j < r_wait; j++) begin
      chk("r_wait_rready", M_RREADY, 1);
      chk("r_wait_arvalid", M_ARVALID, 0);
      chk("r_wait_busy", BUSY, 1);
      chk("r_wait_dvalid", DATA_FROM_AXIM_VALID, 0);
      chk("r_wait_fault", ACCESS_FAULT, 0);
      if (j < foreign) begin
        M_RVALID = 1'b1;
        M_RID = 4'd5;
        M_RDATA = ~rdata;
        M_RRESP = 2'b10;
      end else begin
        M_RVALID = 1'b0;
      end
      FLUSH = (c == flush_at);
      flushed |= FLUSH;
      @(negedge CLK);
      c++;
    end
    chk("r_beat_rready", M_RREADY, 1);
    M_RVALID = 1'b1;
    M_RID = PtwId;
    M_RDATA = rdata;
    M_RRESP = resp;
    FLUSH = (c == flush_at);
    flushed |= FLUSH;
    @(negedge CLK);
    M_RVALID = 1'b0;
    M_RRESP = 2'b00;
    FLUSH = 1'b0;
    exp_dv = !flushed && !(CheckEn && resp[1]);
    exp_f  = !flushed && CheckEn && resp[1];
    if (exp_dv) model_data = rdata;
    chk("resp_dvalid", DATA_FROM_AXIM_VALID, exp_dv);
    chk("resp_fault", ACCESS_FAULT, exp_f);
    chk("resp_data", DATA_FROM_AXIM, model_data);
    chk("resp_busy", BUSY, 0);
    @(negedge CLK);
    chk("post_dvalid", DATA_FROM_AXIM_VALID, 0);
    chk("post_fault", ACCESS_FAULT, 0);
    chk("post_data", DATA_FROM_AXIM, model_data);
    chk("post_busy", BUSY, 0);
  endtask

  initial begin
    RST = 1'b0;
    ADDR_TO_AXIM_VALID = 1'b0;
    ADDR_TO_AXIM = '0;
    FLUSH = 1'b0;
    M_ARREADY = 1'b0;
    M_RID = '0;
    M_RDATA = '0;
    M_RRESP = 2'b00;
    M_RLAST = 1'b1;
    M_RVALID = 1'b0;
    model_data = '0;
    repeat (2) @(negedge CLK);
    chk("rst_arvalid", M_ARVALID, 0);
    chk("rst_rready", M_RREADY, 0);
    chk("rst_araddr", M_ARADDR, 0);
    chk("rst_dvalid", DATA_FROM_AXIM_VALID, 0);
    chk("rst_data", DATA_FROM_AXIM, 0);
    chk("rst_fault", ACCESS_FAULT, 0);
    chk("rst_busy", BUSY, 0);
    chk("const_arid", M_ARID, 0);
    chk("const_arburst", M_ARBURST, 2'b01);
    chk("const_arprot", M_ARPROT, 3'b001);
    RST = 1'b1;
    @(negedge CLK);

    // Zero-wait path, cycle by cycle.
    ADDR_TO_AXIM_VALID = 1'b1;
    ADDR_TO_AXIM = 64'h0000_0000_8000_1238;
    @(negedge CLK);
    ADDR_TO_AXIM_VALID = 1'b0;
    chk("zw_c1_arvalid", M_ARVALID, 1);
    chk("zw_c1_araddr", M_ARADDR, 64'h0000_0000_8000_1238);
    chk("zw_c1_arlen", M_ARLEN, 0);
    chk("zw_c1_arsize", M_ARSIZE, 3);
    chk("zw_c1_rready", M_RREADY, 0);
    M_ARREADY = 1'b1;
    @(negedge CLK);
    M_ARREADY = 1'b0;
    chk("zw_c2_arvalid", M_ARVALID, 0);
    chk("zw_c2_rready", M_RREADY, 1);
    chk("zw_c2_dvalid", DATA_FROM_AXIM_VALID, 0);
    M_RVALID = 1'b1;
    M_RID = PtwId;
    M_RDATA = 64'h0000_0000_2000_00CF;
    M_RRESP = 2'b00;
    @(negedge CLK);
    M_RVALID = 1'b0;
    model_data = 64'h0000_0000_2000_00CF;
    chk("zw_c3_dvalid", DATA_FROM_AXIM_VALID, 1);
    chk("zw_c3_data", DATA_FROM_AXIM, model_data);
    chk("zw_c3_busy", BUSY, 0);
    @(negedge CLK);
    chk("zw_c4_dvalid", DATA_FROM_AXIM_VALID, 0);

    // Unaligned request address: low bits cleared on ARADDR.
    walk(64'h0000_0001_0000_0107, 0, 0, -1, 0, 2'b00, 64'h1111_2222_3333_4444, 1'b0);
    // Backpressure.
    walk(64'h0000_0000_8000_2000, 5, 7, -1, 0, 2'b00, 64'hA5A5_0000_0000_5A5A, 1'b0);
    // Flush while waiting for RVALID, beat at cycle 6, then a normal walk.
    walk(64'h0000_0000_8000_3008, 0, 4, 2, 0, 2'b00, 64'hDEAD_BEEF_0000_0001, 1'b0);
    walk(64'h0000_0000_8000_3010, 0, 0, -1, 0, 2'b00, 64'h0000_0000_3000_00C1, 1'b0);
    // Flush during AR.
    walk(64'h0000_0000_8000_4000, 3, 1, 2, 0, 2'b00, 64'hFFFF_0000_FFFF_0000, 1'b0);
    // Dropped second request and a foreign-ID beat.
    walk(64'h0000_0000_8000_5000, 2, 3, -1, 1, 2'b00, 64'h0000_0000_4000_00DF, 1'b1);
    // Bus error.
    walk(64'h0000_0000_8000_6000, 1, 1, -1, 0, 2'b10, 64'h0BAD_0BAD_0BAD_0BAD, 1'b0);
    walk(64'h0000_0000_8000_6008, 0, 0, -1, 0, 2'b11, 64'h0BAD_0BAD_0000_0000, 1'b0);

    // Flush coincident with a request in IDLE drops the request.
    ADDR_TO_AXIM_VALID = 1'b1;
    ADDR_TO_AXIM = 64'h0000_0000_9000_0000;
    FLUSH = 1'b1;
    @(negedge CLK);
    ADDR_TO_AXIM_VALID = 1'b0;
    FLUSH = 1'b0;
    chk("idle_flush_busy", BUSY, 0);
    chk("idle_flush_arvalid", M_ARVALID, 0);

    // Asynchronous reset while in AR.
    ADDR_TO_AXIM_VALID = 1'b1;
    ADDR_TO_AXIM = 64'h0000_0000_8000_7000;
    @(negedge CLK);
    ADDR_TO_AXIM_VALID = 1'b0;
    chk("arst_pre_arvalid", M_ARVALID, 1);
    #2 RST = 1'b0;
    #1;
    chk("arst_arvalid", M_ARVALID, 0);
    chk("arst_rready", M_RREADY, 0);
    chk("arst_busy", BUSY, 0);
    model_data = '0;
    chk("arst_data", DATA_FROM_AXIM, model_data);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("arst_rel_busy", BUSY, 0);
    walk(64'h0000_0000_8000_7008, 1, 2, -1, 0, 2'b00, 64'h0000_0000_5000_00CF, 1'b0);

    // Randomized walks.
    for (int k = 0; k < 24; k++) begin
      int aw;
      int rw;
      int fa;
      int fr;
      aw = int'($urandom_range(4, 0));
      rw = int'($urandom_range(4, 0));
      fa = ($urandom_range(3, 0) == 0) ? int'($urandom_range(aw + rw + 2, 1)) : -1;
      fr = int'($urandom_range(rw, 0));
      walk({$urandom, $urandom}, aw, rw, fa, fr, 2'($urandom_range(3, 0)),
           {$urandom, $urandom}, 1'($urandom_range(1, 0)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
